// File: rtl/approx_mon_pkg.sv
// rtl/approx_mon_pkg.sv - shared FSM state type and width helpers for approx_error_monitor
package approx_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N            = 16;
    localparam int DEF_SAMPLES_LOG2 = 10;

    // Default-configuration widths; parameterised instances use the helpers below.
    localparam int ED_W  = DEF_N + 1;
    localparam int CNT_W = DEF_SAMPLES_LOG2 + 1;
    localparam int SUM_W = ED_W + DEF_SAMPLES_LOG2;

    function automatic int ed_w(input int n);
        return n + 1;
    endfunction

    function automatic int cnt_w(input int samples_log2);
        return samples_log2 + 1;
    endfunction

    function automatic int sum_w(input int n, input int samples_log2);
        return n + 1 + samples_log2;
    endfunction

endpackage

// File: rtl/approx_err_dist.sv
// rtl/approx_err_dist.sv - combinational exact sum, error distance and signed error (APPROX_MON_BIAS_EN)
module approx_err_dist #(
    parameter int N = 16
) (
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    input  logic [N-1:0]        s,
    output logic [N:0]          exact,
    output logic [N:0]          ed
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic signed [N+1:0] err
`endif
);

    logic [N:0] s_ext;

    // The approximate adder has no carry-out, so a dropped carry shows up as a large distance.
    always_comb begin
        exact = {1'b0, a} + {1'b0, b};
        s_ext = {1'b0, s};
        ed    = (exact >= s_ext) ? (exact - s_ext) : (s_ext - exact);
    end

`ifdef APPROX_MON_BIAS_EN
    // Signed approx - exact; one extra bit keeps the full +/- range representable.
    always_comb begin
        err = signed'({1'b0, s_ext}) - signed'({1'b0, exact});
    end
`endif

endmodule

// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - windowed accuracy statistics for an approximate adder (optional APPROX_MON_BIAS_EN)
module approx_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int N            = 16,
    parameter int K            = 8,
    parameter int SAMPLES_LOG2 = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 in_a,
    input  logic [N-1:0]                 in_b,
    input  logic [N-1:0]                 in_s,
    output logic                         busy,
    output logic                         done,
    output logic [SAMPLES_LOG2:0]        smp_count,
    output logic [SAMPLES_LOG2:0]        err_count,
    output logic [N+SAMPLES_LOG2:0]      sum_ed,
    output logic [N:0]                   max_ed
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic signed [N+1+SAMPLES_LOG2:0] sum_err
`endif
);

    localparam int EW = ed_w(N);
    localparam int CW = cnt_w(SAMPLES_LOG2);
    localparam int SW = sum_w(N, SAMPLES_LOG2);
    localparam logic [CW-1:0] WINDOW = CW'(1) << SAMPLES_LOG2;

    // K only describes the upstream adder; reject configurations where it cannot fit.
    if (K > N) begin : g_bad_k
        $error("approx_error_monitor: K must not exceed N");
    end

    state_t        state;
    logic          drain_cnt;
    logic          accept;
    logic          clear;
    logic [EW-1:0] exact;
    logic [EW-1:0] ed;
    logic          s1_valid;
    logic [EW-1:0] s1_ed;

    assign in_ready = (state == RUN) && (smp_count < WINDOW);
    assign accept   = in_valid && in_ready;
    assign clear    = start && ((state == IDLE) || (state == DONE));
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

`ifdef APPROX_MON_BIAS_EN
    logic signed [EW:0] err;
    logic signed [EW:0] s1_err;

    approx_err_dist #(.N(N)) u_err_dist (
        .a     (in_a),
        .b     (in_b),
        .s     (in_s),
        .exact (exact),
        .ed    (ed),
        .err   (err)
    );
`else
    approx_err_dist #(.N(N)) u_err_dist (
        .a     (in_a),
        .b     (in_b),
        .s     (in_s),
        .exact (exact),
        .ed    (ed)
    );
`endif

    // Window control: start clears, accepts count up, two drain cycles flush both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            smp_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        smp_count <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        smp_count <= smp_count + 1'b1;
                        if (smp_count == WINDOW - 1'b1) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: capture the error terms of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
`ifdef APPROX_MON_BIAS_EN
            s1_err   <= '0;
`endif
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ed  <= ed;
`ifdef APPROX_MON_BIAS_EN
                s1_err <= err;
`endif
            end
        end
    end

    // Stage 2: fold stage-1 terms into the window statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
`ifdef APPROX_MON_BIAS_EN
            sum_err   <= '0;
`endif
        end else if (clear) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
`ifdef APPROX_MON_BIAS_EN
            sum_err   <= '0;
`endif
        end else if (s1_valid) begin
            if (s1_ed != '0) begin
                err_count <= err_count + 1'b1;
            end
            sum_ed <= sum_ed + SW'(s1_ed);
            if (s1_ed > max_ed) begin
                max_ed <= s1_ed;
            end
`ifdef APPROX_MON_BIAS_EN
            sum_err <= sum_err + (SW+1)'(s1_err);
`endif
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb/tb_approx_error_monitor.sv - scoreboard bench for approx_error_monitor (N=16, window 4; APPROX_MON_BIAS_EN aware)
module tb_approx_error_monitor;

    localparam int N  = 16;
    localparam int L2 = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic [N-1:0]  in_s = '0;
    logic          busy;
    logic          done;
    logic [L2:0]   smp_count;
    logic [L2:0]   err_count;
    logic [N+L2:0] sum_ed;
    logic [N:0]    max_ed;
    logic [N+1+L2:0] sum_err_w;

    typedef struct {
        logic [L2:0]     smp;
        logic [L2:0]     errc;
        logic [N+L2:0]   sum;
        logic [N:0]      mx;
        logic [N+1+L2:0] se;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    approx_error_monitor #(.N(N), .K(8), .SAMPLES_LOG2(L2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_s      (in_s),
        .busy      (busy),
        .done      (done),
        .smp_count (smp_count),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed)
`ifdef APPROX_MON_BIAS_EN
        ,
        .sum_err   (sum_err_w)
`endif
    );

`ifndef APPROX_MON_BIAS_EN
    assign sum_err_w = '0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [L2:0] smp, input logic [L2:0] errc,
                            input logic [N+L2:0] sum, input logic [N:0] mx,
                            input logic [N+1+L2:0] se);
        exp_t e;
        e.smp = smp; e.errc = errc; e.sum = sum; e.mx = mx; e.se = se;
        exp_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] s);
        bit ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_s = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1 ok = 1;
            end
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: compare window results against the queued expectation when done rises.
    initial begin
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("smp_count", 64'(smp_count), 64'(e.smp));
                    chk("err_count", 64'(err_count), 64'(e.errc));
                    chk("sum_ed",    64'(sum_ed),    64'(e.sum));
                    chk("max_ed",    64'(max_ed),    64'(e.mx));
`ifdef APPROX_MON_BIAS_EN
                    chk("sum_err",   64'(sum_err_w), 64'(e.se));
`endif
                end
            end
            prev_done = done;
        end
    end

    initial begin
        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_smp_count", 64'(smp_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_sum_ed",    64'(sum_ed),    64'd0);
        chk("rst_max_ed",    64'(max_ed),    64'd0);
`ifdef APPROX_MON_BIAS_EN
        chk("rst_sum_err",   64'(sum_err_w), 64'd0);
`endif
        rst_n = 1'b1;

        // 2: all-exact window plus done latency
        do_start();
        push_exp(3'd4, 3'd0, '0, '0, '0);
        chk("t2_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) send(16'h0001, 16'h0001, 16'h0002);
        @(negedge clk); chk("t2_done_lat0", 64'(done), 64'd0);
        @(negedge clk); chk("t2_done_lat1", 64'(done), 64'd0);
        @(negedge clk); chk("t2_done_lat2", 64'(done), 64'd1);

        // 3: dropped carry counts as full error
        do_start();
        push_exp(3'd4, 3'd1, 19'h10000, 17'h10000, 20'hF0000);
        send(16'hFFFF, 16'h0001, 16'h0000);
        send(16'h0005, 16'h0006, 16'h000B);
        send(16'h1000, 16'h2000, 16'h3000);
        send(16'h00FF, 16'h0001, 16'h0100);
        wait_done();

        // 4: errors both sides of exact
        do_start();
        push_exp(3'd4, 3'd2, 19'd8, 17'd5, 20'h00002);
        send(16'h0010, 16'h0010, 16'h001D);
        send(16'h0010, 16'h0010, 16'h0025);
        send(16'h0010, 16'h0010, 16'h0020);
        send(16'h0010, 16'h0010, 16'h0020);
        wait_done();

        // 5: toggled in_valid, then a 5th sample offered after the window is full
        do_start();
        push_exp(3'd4, 3'd3, 19'h10007, 17'h10000, 20'hEFFFD);
        send(16'h0100, 16'h0200, 16'h0300);
        @(posedge clk); #1;
        send(16'h1234, 16'h1111, 16'h2340);
        @(posedge clk); #1;
        send(16'h8000, 16'h8000, 16'h0000);
        @(posedge clk); #1;
        send(16'h0003, 16'h0004, 16'h0009);
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_s = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_in_ready_full", 64'(in_ready),  64'd0);
            chk("t5_smp_hold",      64'(smp_count), 64'd4);
        end
        in_valid = 1'b0;
        wait_done();

        // 6: reset mid-window, then a clean window
        do_start();
        send(16'h0001, 16'h0002, 16'h0000);
        send(16'h0001, 16'h0002, 16'h0000);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("t6_smp_count", 64'(smp_count), 64'd0);
        chk("t6_in_ready",  64'(in_ready),  64'd0);
        chk("t6_busy",      64'(busy),      64'd0);
        chk("t6_sum_ed",    64'(sum_ed),    64'd0);
        rst_n = 1'b1;
        do_start();
        push_exp(3'd4, 3'd1, 19'd1, 17'd1, 20'h00001);
        send(16'h0000, 16'h0000, 16'h0001);
        send(16'h0002, 16'h0002, 16'h0004);
        send(16'h0003, 16'h0003, 16'h0006);
        send(16'h0004, 16'h0004, 16'h0008);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
